wbsrc_sel_pipe: RTL and testbench

Parametrised, registered writeback-source stage. It replaces the purely combinational ALU/MEM/PC+4/SLT select with one pipelined block. The block accepts one writeback request per handshake and waits on a variable-latency load return. It performs byte/half/word (and dword when DATA_W=64) load extraction with sign or zero extension, and drives the register-file write port. It sits between the MEM stage and the register file.

---
 rtl/wbsrc_sel_pipe.sv | 150 +++++++++++++++
 tb/tb_wbsrc_sel_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbsrc_sel_pipe.sv
// Registered writeback-source stage: selects ALU / load / PC+4 / SLT data,
// waits on a variable-latency load return and drives the register-file port.
module wbsrc_sel_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  localparam int LW         = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic              in_we,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_aludata,
  input  logic [DATA_W-1:0] in_pcdata,
  input  logic              in_negative,
  input  logic [1:0]        in_lsize,
  input  logic              in_lunsigned,
  input  logic [LW-1:0]     in_addrlo,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_timeout,
  output logic              dbg_state
);

  localparam int CW = $clog2(MEM_TIMEOUT);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                cap_we;
  logic [REG_AW-1:0]   cap_rd;
  logic [1:0]          cap_lsize;
  logic                cap_unsigned;
  logic [LW-1:0]       cap_addrlo;
  logic [DATA_W-1:0]   direct_data;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so at most one request is in flight.
  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        lsize,
    input logic              uns,
    input logic [LW-1:0]     addrlo
  );
    logic [1:0]        sz;
    logic [LW-1:0]     lane;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sz   = (lsize == 2'b11 && DATA_W == 32) ? 2'b10 : lsize;
    // Misaligned addresses are truncated down to the access alignment.
    lane = addrlo & ~((LW'(1) << sz) - LW'(1));
    sh   = raw >> {lane, 3'b000};
    case (sz)
      2'b00:   res = uns ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
      2'b01:   res = uns ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
      2'b10:   res = uns ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
      default: res = sh;
    endcase
    return res;
  endfunction

  always_comb begin
    direct_data = '0;
    case (in_sel)
      2'b00:   direct_data = in_aludata;
      2'b10:   direct_data = in_pcdata;
      2'b11:   direct_data = DATA_W'(in_negative);
      default: direct_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_rd       <= '0;
      cap_lsize    <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addrlo   <= '0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      err_timeout  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_sel != 2'b01) begin
              wb_valid <= 1'b1;
              wb_we    <= in_we & (in_rd != '0);
              wb_rd    <= in_rd;
              wb_data  <= direct_data;
            end else if (mem_rvalid) begin
              wb_valid <= 1'b1;
              wb_we    <= in_we & (in_rd != '0);
              wb_rd    <= in_rd;
              wb_data  <= load_extract(mem_rdata, in_lsize, in_lunsigned, in_addrlo);
            end else begin
              cap_we       <= in_we;
              cap_rd       <= in_rd;
              cap_lsize    <= in_lsize;
              cap_unsigned <= in_lunsigned;
              cap_addrlo   <= in_addrlo;
              cnt          <= '0;
              state        <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // Returning data takes priority over an expiring timeout.
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= cap_we & (cap_rd != '0);
            wb_rd    <= cap_rd;
            wb_data  <= load_extract(mem_rdata, cap_lsize, cap_unsigned, cap_addrlo);
            state    <= IDLE;
          end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
            wb_valid    <= 1'b1;
            wb_we       <= 1'b0;
            wb_rd       <= cap_rd;
            wb_data     <= '0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbsrc_sel_pipe.sv
// Bench for wbsrc_sel_pipe: directed scenarios plus randomized requests,
// with writebacks checked in order against a reference-model scoreboard.
module tb_wbsrc_sel_pipe;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TMO = 4;
  localparam int W   = 39;  // {rd_dont_care, we, rd[4:0], data[31:0]}

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic          in_we;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_aludata;
  logic [DW-1:0] in_pcdata;
  logic          in_negative;
  logic [1:0]    in_lsize;
  logic          in_lunsigned;
  logic [1:0]    in_addrlo;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          err_timeout;
  logic          dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  e;
  logic [DW-1:0] last_data;
  int            checks = 0;
  int            errors = 0;

  wbsrc_sel_pipe #(.DATA_W(DW), .REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_we(in_we), .in_rd(in_rd), .in_aludata(in_aludata),
    .in_pcdata(in_pcdata), .in_negative(in_negative), .in_lsize(in_lsize),
    .in_lunsigned(in_lunsigned), .in_addrlo(in_addrlo), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [31:0] ref_load(input logic [31:0] raw, input int lsize,
                                           input bit uns, input int addrlo);
    int     nb;
    int     off;
    longint span;
    longint v;
    nb = 1 << lsize;
    if (nb > DW/8) nb = DW/8;
    off  = (addrlo / nb) * nb;
    span = longint'(1) << (nb * 8);
    v    = longint'({32'h0, raw}) >> (off * 8);
    v    = v % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_direct(input int sel, input logic [31:0] alu,
                                             input logic [31:0] pc, input logic neg);
    if (sel == 0) return alu;
    if (sel == 2) return pc;
    return neg ? 32'd1 : 32'd0;
  endfunction

  task automatic push_exp(input logic dc, input logic we, input logic [AW-1:0] rd,
                          input logic [31:0] data);
    exp_q.push_back({dc, we & (rd != 5'd0), rd, data});
  endtask

  // Driver tasks
  task automatic present(input logic [1:0] sel, input logic we, input logic [AW-1:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc, input logic neg,
                         input logic [1:0] lsize, input logic uns, input logic [1:0] alo,
                         input logic rv, input logic [31:0] rdata);
    in_valid = 1'b1; in_sel = sel; in_we = we; in_rd = rd;
    in_aludata = alu; in_pcdata = pc; in_negative = neg;
    in_lsize = lsize; in_lunsigned = uns; in_addrlo = alo;
    mem_rvalid = rv; mem_rdata = rdata;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Data is sampled d rising edges after the accepting edge.
  task automatic pulse_rvalid(input int d, input logic [31:0] rdata);
    for (int k = 1; k < d; k++) begin
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, required no writeback",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_we !== e[37] || wb_data !== e[31:0] || (!e[38] && wb_rd !== e[36:32])) begin
          errors++;
          $display("FAIL wb_entry: got we=%b rd=%0d data=%h, required we=%b rd=%0d data=%h",
                   wb_we, wb_rd, wb_data, e[37], e[36:32], e[31:0]);
        end
        last_data = e[31:0];
      end
    end
  end

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_we = 1'b0; in_rd = '0;
    in_aludata = '0; in_pcdata = '0; in_negative = 1'b0; in_lsize = 2'b00;
    in_lunsigned = 1'b0; in_addrlo = 2'b00; mem_rvalid = 1'b0; mem_rdata = '0;
    last_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b we=%b rd=%0d data=%h err=%b, required all 0",
               wb_valid, wb_we, wb_rd, wb_data, err_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_alu();
    push_exp(1'b0, 1'b1, 5'd3, 32'h12345678);
    present(2'b00, 1'b1, 5'd3, 32'h12345678, 32'h0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL alu_latency: got wb_valid=%b, required 1", wb_valid);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL alu_pulse: got wb_valid=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_slt_zero();
    push_exp(1'b0, 1'b1, 5'd0, 32'h00000001);
    present(2'b11, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL slt_zero: got valid=%b we=%b, required valid=1 we=0", wb_valid, wb_we);
    end
  endtask

  task automatic test_load_delay();
    push_exp(1'b0, 1'b1, 5'd6, 32'hFFFFFF80);
    present(2'b01, 1'b1, 5'd6, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 32'h0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL load_wait_ready: got %b, required 0", in_ready);
    end
    pulse_rvalid(3, 32'h00800000);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL load_delay_latency: got wb_valid=%b, required 1", wb_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL load_done_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_load_same();
    push_exp(1'b0, 1'b1, 5'd8, 32'h0000BEEF);
    present(2'b01, 1'b1, 5'd8, 32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 2'b11, 1'b1, 32'hBEEF0000);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL load_same_latency: got wb_valid=%b, required 1", wb_valid);
    end
  endtask

  task automatic test_timeout_race();
    push_exp(1'b0, 1'b1, 5'd7, 32'hCAFEF00D);
    present(2'b01, 1'b1, 5'd7, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 32'h0);
    pulse_rvalid(TMO, 32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_race: got valid=%b err=%b, required valid=1 err=0", wb_valid, err_timeout);
    end
  endtask

  task automatic test_timeout();
    int n;
    push_exp(1'b1, 1'b0, 5'd5, 32'h0);
    present(2'b01, 1'b1, 5'd5, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb_valid !== 1'b1 && n < 20);
    checks++;
    if (n != TMO + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d edges, required %0d", n, TMO + 1);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_flag: got %b, required 1", err_timeout);
    end
    push_exp(1'b0, 1'b1, 5'd12, 32'h0BADF00D);
    present(2'b00, 1'b1, 5'd12, 32'h0BADF00D, 32'h0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after: got valid=%b err=%b, required valid=1 err=1", wb_valid, err_timeout);
    end
  endtask

  task automatic test_rvalid_ignored();
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== last_data) begin
      errors++;
      $display("FAIL rvalid_ignored: got valid=%b data=%h, required valid=0 data=%h",
               wb_valid, wb_data, last_data);
    end
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 1'b1, 5'd9, 32'h89ABCDEF);
    push_exp(1'b0, 1'b1, 5'd10, 32'h00001234);
    present(2'b01, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 32'h0);
    // Hold an ALU request while the load is outstanding; it must wait its turn.
    in_valid = 1'b1; in_sel = 2'b00; in_rd = 5'd10; in_aludata = 32'h00001234;
    in_lsize = 2'b00; in_lunsigned = 1'b1; in_addrlo = 2'b11;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h89ABCDEF;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL busy_hold: got wb_valid=%b, required 0", wb_valid);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL busy_release: got wb_valid=%b, required 1", wb_valid);
    end
  endtask

  task automatic test_random(input int n);
    logic [1:0]  sel;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        neg;
    logic [1:0]  lsize;
    logic        uns;
    logic [1:0]  alo;
    logic [31:0] rdata;
    int          mode;
    for (int i = 0; i < n; i++) begin
      sel   = 2'($urandom_range(0, 3));
      we    = 1'($urandom_range(0, 1));
      rd    = 5'($urandom_range(0, 31));
      alu   = $urandom;
      pc    = $urandom;
      neg   = 1'($urandom_range(0, 1));
      lsize = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      alo   = 2'($urandom_range(0, 3));
      rdata = $urandom;
      mode  = $urandom_range(0, 2);
      if (sel != 2'b01) begin
        push_exp(1'b0, we, rd, ref_direct(int'(sel), alu, pc, neg));
        present(sel, we, rd, alu, pc, neg, lsize, uns, alo, 1'b0, rdata);
      end else if (mode == 0) begin
        push_exp(1'b0, we, rd, ref_load(rdata, int'(lsize), uns, int'(alo)));
        present(sel, we, rd, alu, pc, neg, lsize, uns, alo, 1'b1, rdata);
      end else if (mode == 1) begin
        push_exp(1'b0, we, rd, ref_load(rdata, int'(lsize), uns, int'(alo)));
        present(sel, we, rd, alu, pc, neg, lsize, uns, alo, 1'b0, 32'h0);
        pulse_rvalid($urandom_range(1, TMO), rdata);
      end else begin
        push_exp(1'b1, 1'b0, rd, 32'h0);
        present(sel, we, rd, alu, pc, neg, lsize, uns, alo, 1'b0, 32'h0);
        repeat (TMO) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    present(2'b01, 1'b1, 5'd4, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got valid=%b ready=%b err=%b, required 0 1 0",
               wb_valid, in_ready, err_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_data = '0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_drop: got valid=%b we=%b rd=%0d data=%h ready=%b, required zeros and ready=1",
               wb_valid, wb_we, wb_rd, wb_data, in_ready);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_alu();
    test_slt_zero();
    test_load_delay();
    test_load_same();
    test_rvalid_ignored();
    test_timeout_race();
    test_timeout();
    test_back_to_back();
    test_random(150);
    test_reset_mid_wait();
    test_alu();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
